// File: rtl/d_drain_pkg.sv
// Shared constants and state codes for the D-side FIFO drain.
package d_drain_pkg;
  localparam int DATA_W_DEF = 6;
  localparam int CNT_W_DEF  = 8;
  localparam int DEST_BIT   = 4;
  localparam int VC_BIT     = 5;

  // State codes are plain 3-bit constants so older tools can read the encoding.
  typedef logic [2:0] state_t;
  localparam state_t ST_RESET  = 3'd0;
  localparam state_t ST_INIT   = 3'd1;
  localparam state_t ST_IDLE   = 3'd2;
  localparam state_t ST_ACTIVE = 3'd3;
  localparam state_t ST_ERROR  = 3'd4;
endpackage

// File: rtl/drain_out_buf.sv
// Two-entry order-preserving output buffer; entry 0 is always the head.
module drain_out_buf #(
  parameter int W = 7
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         enq,
  input  logic         deq,
  input  logic [W-1:0] din,
  output logic [W-1:0] head,
  output logic [1:0]   occ
);
  logic [W-1:0] e0_q, e0_d, e1_q, e1_d;
  logic [1:0]   occ_q, occ_d;
  logic         do_enq, do_deq;

  always_comb begin
    e0_d   = e0_q;
    e1_d   = e1_q;
    occ_d  = occ_q;
    do_deq = deq & (occ_q != 2'd0);
    do_enq = enq & ((occ_q != 2'd2) | do_deq);
    case (occ_q)
      2'd0: if (do_enq) begin
        e0_d  = din;
        occ_d = 2'd1;
      end
      2'd1: begin
        if (do_enq & do_deq) e0_d = din;
        else if (do_enq) begin
          e1_d  = din;
          occ_d = 2'd2;
        end else if (do_deq) occ_d = 2'd0;
      end
      default: if (do_deq) begin
        e0_d = e1_q;
        if (do_enq) e1_d = din;
        else occ_d = 2'd1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      e0_q  <= '0;
      e1_q  <= '0;
      occ_q <= 2'd0;
    end else begin
      e0_q  <= e0_d;
      e1_q  <= e1_d;
      occ_q <= occ_d;
    end
  end

  assign head = e0_q;
  assign occ  = occ_q;
endmodule

// File: rtl/d_fifo_drain.sv
// Drains D0/D1 destination FIFOs round-robin into one valid/ready stream,
// checking each word's destination bit and keeping per-destination counts.
module d_fifo_drain
  import d_drain_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              init,
  input  logic              empty_fifo_D0,
  input  logic              empty_fifo_D1,
  input  logic [DATA_W-1:0] data_out_D0,
  input  logic [DATA_W-1:0] data_out_D1,
  input  logic              error_D0,
  input  logic              error_D1,
  output logic              D0_pop,
  output logic              D1_pop,
  output logic [DATA_W-1:0] data_out,
  output logic              valid_out,
  input  logic              ready_in,
  output logic              dest_out,
  output logic [CNT_W-1:0]  count_D0,
  output logic [CNT_W-1:0]  count_D1,
  output logic              error_out,
  output logic              active_out,
  output logic              idle_out
);
  state_t            state_q, state_d;
  logic              rr_q, rr_d, inflight_q, inflight_d, src_q, src_d;
  logic [CNT_W-1:0]  cnt0_q, cnt0_d, cnt1_q, cnt1_d;
  logic              err_q, err_d, act_q, act_d, idle_q, idle_d;
  logic [1:0]        occ;
  logic [DATA_W:0]   head;
  logic [DATA_W-1:0] word;
  logic              deq, enq, mismatch, can_pop, elig0, elig1, busy;
  logic [2:0]        pend;

  assign valid_out = (occ != 2'd0);
  assign deq       = valid_out & ready_in;
  assign word      = src_q ? data_out_D1 : data_out_D0;
  assign mismatch  = inflight_q & (word[DEST_BIT] != src_q);
  assign enq       = inflight_q & ~mismatch;
  assign busy      = ~empty_fifo_D0 | ~empty_fifo_D1 | valid_out | inflight_q;

  // Count the in-flight word against buffer space so a full buffer never overflows.
  always_comb begin
    pend    = {1'b0, occ} + {2'b0, inflight_q} - {2'b0, deq};
    can_pop = ~reset & ~init & ((state_q == ST_IDLE) | (state_q == ST_ACTIVE)) & (pend < 3'd2);
    elig0   = can_pop & ~empty_fifo_D0;
    elig1   = can_pop & ~empty_fifo_D1;
    D0_pop  = elig0 & (~elig1 | ~rr_q);
    D1_pop  = elig1 & (~elig0 | rr_q);
  end

  always_comb begin
    state_d    = state_q;
    rr_d       = rr_q;
    cnt0_d     = cnt0_q;
    cnt1_d     = cnt1_q;
    inflight_d = D0_pop | D1_pop;
    src_d      = D1_pop;
    if (elig0 & elig1) rr_d = ~rr_q;
    if (enq & ~src_q) cnt0_d = cnt0_q + 1'b1;
    if (enq & src_q)  cnt1_d = cnt1_q + 1'b1;
    case (state_q)
      ST_RESET:            state_d = ST_INIT;
      ST_INIT:             state_d = ST_IDLE;
      ST_IDLE, ST_ACTIVE:  state_d = busy ? ST_ACTIVE : ST_IDLE;
      default:             state_d = ST_ERROR;
    endcase
    if ((state_q != ST_RESET) & (mismatch | error_D0 | error_D1)) state_d = ST_ERROR;
    if (init) begin
      state_d = ST_INIT;
      rr_d    = 1'b0;
      cnt0_d  = '0;
      cnt1_d  = '0;
    end
    err_d  = (state_q == ST_ERROR);
    act_d  = (state_q == ST_ACTIVE);
    idle_d = (state_q == ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_RESET;
      rr_q       <= 1'b0;
      inflight_q <= 1'b0;
      src_q      <= 1'b0;
      cnt0_q     <= '0;
      cnt1_q     <= '0;
      err_q      <= 1'b0;
      act_q      <= 1'b0;
      idle_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_q       <= rr_d;
      inflight_q <= inflight_d;
      src_q      <= src_d;
      cnt0_q     <= cnt0_d;
      cnt1_q     <= cnt1_d;
      err_q      <= err_d;
      act_q      <= act_d;
      idle_q     <= idle_d;
    end
  end

  drain_out_buf #(.W(DATA_W + 1)) u_buf (
    .clk   (clk),
    .reset (reset),
    .enq   (enq),
    .deq   (deq),
    .din   ({src_q, word}),
    .head  (head),
    .occ   (occ)
  );

  assign data_out   = head[DATA_W-1:0];
  assign dest_out   = head[DATA_W];
  assign count_D0   = cnt0_q;
  assign count_D1   = cnt1_q;
  assign error_out  = err_q;
  assign active_out = act_q;
  assign idle_out   = idle_q;
endmodule

// File: doc/d_fifo_drain.md
# d_fifo_drain

Consumer on the D-side of the transmission-layer FIFO tree: pops destination FIFOs D0 and D1 whenever they hold data, merges both streams into one valid/ready output through a 2-entry buffer, and checks each word's destination bit against the FIFO it came from. Round-robin arbitration gives equal service when both FIFOs are non-empty. It also keeps per-destination word counters and reports init/idle/active/error status with the same meaning as the FIFO-tree status outputs.

## Interface
Parameters:
- DATA_W, 6, word width, matching data_out_D0/D1.
- CNT_W, 8, per-destination counter width.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high.
- init  in  1  level; while high, clears counters and error, no pops.
- empty_fifo_D0, empty_fifo_D1  in  1 each  D-FIFO empty flags.
- data_out_D0, data_out_D1  in  DATA_W each  D-FIFO read data, valid the cycle after the pop.
- error_D0, error_D1  in  1 each  D-FIFO overflow/underflow errors.
- D0_pop, D1_pop  out  1 each  combinational pop requests, at most one high per cycle.
- data_out  out  DATA_W  merged output word (buffer head).
- valid_out  out  1  data_out valid.
- ready_in  in  1  downstream accepts when valid_out & ready_in.
- dest_out  out  1  source FIFO of data_out (0 = D0, 1 = D1).
- count_D0, count_D1  out  CNT_W each  accepted-word counters, wrap modulo 2^CNT_W.
- error_out, active_out, idle_out  out  1 each  registered status flags.

## Operation
- Word format: bit 4 is the destination (0 = D0, 1 = D1); bit 5 is the VC tag and passes through unchecked.
- Eligibility: Dx is eligible when its empty flag is 0, state is IDLE or ACTIVE, and occ + inflight − (valid_out & ready_in) < 2. occ is buffer occupancy (0–2). inflight is 1 if a pop was issued last cycle.
- Arbitration: only one FIFO eligible → pop it. Both eligible → pop the FIFO rr_ptr names, then set rr_ptr to the other FIFO. rr_ptr resets to D0.
- Capture: the cycle after Dx_pop, the word is sampled from data_out_Dx.
  - bit 4 == x → enqueue with dest = x and increment count_Dx.
  - bit 4 != x → drop the word (no enqueue, no count) and go to ERROR.
- Buffer: 2-entry FIFO. Same-cycle enqueue and dequeue are legal at any occupancy. Order is preserved.
- State machine, states RESET, INIT, IDLE, ACTIVE, ERROR:
  - RESET → INIT on the first cycle after reset deasserts.
  - INIT → IDLE when init is low.
  - IDLE ↔ ACTIVE: ACTIVE when any FIFO is non-empty, occ > 0, or inflight. Otherwise IDLE.
  - Any state except RESET → ERROR on a destination mismatch, error_D0, or error_D1.
  - ERROR is sticky. It leaves only via reset, or via init high (→ INIT).
  - Any state → INIT when init is high.
- ERROR and INIT issue no pops. The buffer keeps draining. In ERROR, an in-flight word is still captured and checked.
- INIT clears counters and rr_ptr. It does not flush the buffer.

## Timing
- Reset values: D0_pop = D1_pop = 0, data_out = 0, valid_out = 0, dest_out = 0, counts = 0, error_out = 0, active_out = 0, idle_out = 0, state RESET, occ = 0, inflight = 0.
- Latency: pop in cycle N → capture at edge N+1 → valid_out high in cycle N+2 when the buffer was empty.
- Throughput: one word per cycle sustained while ready_in = 1 and a FIFO is non-empty.
- Status flags are registered decodes of state, valid one cycle after the state changes. idle_out is 1 only in IDLE.
- ready_in low with occ = 2 → no pops. The in-flight accounting never overflows the buffer.
- Reset mid-operation: an in-flight word is discarded and the buffer is emptied.

## Structure
- Package d_drain_pkg holds the state enum, DEST_BIT = 4, VC_BIT = 5, and the DATA_W/CNT_W defaults.
- Sub-module drain_out_buf: the 2-entry FIFO (enq, deq, data+dest in, head out, occ). The arbiter, capture, check, counters and FSM sit in the top module.

## Test plan
- Reset then init pulse: all outputs 0 after reset, idle_out = 1 two cycles after init falls.
- D0 holds 0x03, 0x07 and D1 is empty, ready_in = 1: output is 0x03 then 0x07 with dest 0; count_D0 = 2, count_D1 = 0.
- Both FIFOs hold 3 words (D0: 0x01, 0x02, 0x03; D1: 0x11, 0x12, 0x13): output alternates 0x01, 0x11, 0x02, 0x12, 0x03, 0x13 at one word per cycle.
- Backpressure: ready_in = 0 for 5 cycles with D0 non-empty → exactly 2 pops, then none. Releasing ready_in delivers the words in order with no loss.
- Mismatch: D1 supplies 0x05 (bit 4 = 0) → word dropped, count_D1 unchanged, error_out = 1 and stays 1. An init pulse clears it.
- error_D0 pulse while ACTIVE → ERROR, pops stop, buffered words still drain.
